// File: rtl/sim_cen_gen.sv
// sim_cen_gen
//   Fractional clock-enable generator. Each of CHANNELS channels emits
//   single-cycle cen pulses at an average rate of num/den of clk_sys, using a
//   phase accumulator that wraps modulo den. Ratios can be reprogrammed at
//   runtime, and selected channels can be frozen by pause.
//
//   Optional feature macro: SIM_TURBO_EN
//     When defined, turbo=1 doubles the accumulator step of the channels in
//     TURBO_MASK. When undefined, the turbo port is accepted but has no effect.
//
// Ports
//   clk_sys  in   1         system clock (only clock)
//   reset    in   1         asynchronous, active-high reset
//   pause    in   1         freeze channels in PAUSE_MASK (acc held, cen low)
//   turbo    in   1         double-rate request (SIM_TURBO_EN builds only)
//   cfg_wr   in   1         one-cycle configuration write strobe
//   cfg_ch   in   4         target channel; values >= CHANNELS are ignored
//   cfg_num  in   ACC_W     new numerator
//   cfg_den  in   ACC_W     new denominator (0 disables the channel)
//   cen      out  CHANNELS  registered clock-enable pulses
//   paused   out  1         registered copy of pause
module sim_cen_gen #(
   parameter int                          CHANNELS   = 4,
   parameter int                          ACC_W      = 8,
   parameter logic [CHANNELS*ACC_W-1:0]   DEF_NUM    = {8'd1, 8'd1, 8'd1, 8'd1},
   parameter logic [CHANNELS*ACC_W-1:0]   DEF_DEN    = {8'd4, 8'd12, 8'd8, 8'd2},
   parameter logic [CHANNELS-1:0]         PAUSE_MASK = 4'b0011,
   parameter logic [CHANNELS-1:0]         TURBO_MASK = 4'b0001
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 pause,
   input  logic                 turbo,
   input  logic                 cfg_wr,
   input  logic [3:0]           cfg_ch,
   input  logic [ACC_W-1:0]     cfg_num,
   input  logic [ACC_W-1:0]     cfg_den,
   output logic [CHANNELS-1:0]  cen,
   output logic                 paused
);

   // Two guard bits: acc < den and step <= 2*num, so the sum never overflows.
   localparam int SUM_W = ACC_W + 2;

   logic [ACC_W-1:0]    num_r    [CHANNELS];
   logic [ACC_W-1:0]    den_r    [CHANNELS];
   logic [ACC_W-1:0]    acc_r    [CHANNELS];
   logic [ACC_W:0]      step_res [CHANNELS];
   logic [CHANNELS-1:0] wr_hit;
   logic [CHANNELS-1:0] dbl;

   // One accumulate step: returns {fire, next_acc}.
   // A step that alone reaches den saturates (fire every cycle, acc pinned
   // at 0) so the phase never drifts; den==0 parks the channel.
   function automatic logic [ACC_W:0] acc_step(
      input logic [ACC_W-1:0] acc,
      input logic [ACC_W-1:0] num,
      input logic [ACC_W-1:0] den,
      input logic             dbl_step
   );
      logic [SUM_W-1:0] step;
      logic [SUM_W-1:0] den_x;
      logic [SUM_W-1:0] nxt;
      logic [SUM_W-1:0] rem;
      step  = dbl_step ? ({2'b00, num} << 1) : {2'b00, num};
      den_x = {2'b00, den};
      nxt   = {2'b00, acc} + step;
      rem   = nxt - den_x;
      if (den == '0)
         acc_step = '0;
      else if (step >= den_x)
         acc_step = {1'b1, {ACC_W{1'b0}}};
      else if (nxt >= den_x)
         acc_step = {1'b1, ACC_W'(rem)};
      else
         acc_step = {1'b0, ACC_W'(nxt)};
   endfunction

`ifdef SIM_TURBO_EN
   assign dbl = TURBO_MASK & {CHANNELS{turbo}};
`else
   assign dbl = '0;
   logic unused_turbo;
   assign unused_turbo = &{1'b0, turbo, TURBO_MASK};
`endif

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         // cfg_ch values >= CHANNELS match no channel and are dropped here.
         wr_hit[i]   = cfg_wr && (cfg_ch == 4'(i));
         step_res[i] = acc_step(acc_r[i], num_r[i], den_r[i], dbl[i]);
      end
   end

   // Register stage: accumulators, ratios and cen outputs
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            num_r[i] <= DEF_NUM[i*ACC_W +: ACC_W];
            den_r[i] <= DEF_DEN[i*ACC_W +: ACC_W];
            acc_r[i] <= '0;
         end
         cen    <= '0;
         paused <= 1'b0;
      end else begin
         paused <= pause;
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_hit[i]) begin
               // A write restarts the phase; the new ratio applies next cycle.
               num_r[i] <= cfg_num;
               den_r[i] <= cfg_den;
               acc_r[i] <= '0;
               cen[i]   <= 1'b0;
            end else if (pause && PAUSE_MASK[i]) begin
               // Holding acc lets the channel resume at the exact same phase.
               cen[i] <= 1'b0;
            end else begin
               {cen[i], acc_r[i]} <= step_res[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_sim_cen_gen.sv
// tb_sim_cen_gen
//   Directed bench for sim_cen_gen with default parameters. Expected pulse
//   counts and per-cycle pulse patterns are hand-derived from the ratios.
module tb_sim_cen_gen;

   logic       clk_sys = 1'b0;
   logic       reset   = 1'b1;
   logic       pause   = 1'b0;
   logic       turbo   = 1'b0;
   logic       cfg_wr  = 1'b0;
   logic [3:0] cfg_ch  = 4'd0;
   logic [7:0] cfg_num = 8'd0;
   logic [7:0] cfg_den = 8'd0;
   logic [3:0] cen;
   logic       paused;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cnt [4];
   logic [15:0] pat [4];
   logic [7:0]  exp_turbo;

   sim_cen_gen dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .pause   (pause),
      .turbo   (turbo),
      .cfg_wr  (cfg_wr),
      .cfg_ch  (cfg_ch),
      .cfg_num (cfg_num),
      .cfg_den (cfg_den),
      .cen     (cen),
      .paused  (paused)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic clear();
      for (int c = 0; c < 4; c++) begin
         cnt[c] = 0;
         pat[c] = '0;
      end
   endtask

   // Bit k of pat[c] holds cen[c] after the (k+1)-th edge of the window.
   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         for (int c = 0; c < 4; c++) begin
            if (cen[c]) cnt[c]++;
            if (k < 16) pat[c][k] = cen[c];
         end
      end
   endtask

   task automatic cfg(input logic [3:0] ch, input logic [7:0] n, input logic [7:0] d);
      cfg_wr  = 1'b1;
      cfg_ch  = ch;
      cfg_num = n;
      cfg_den = d;
      tick();
      cfg_wr  = 1'b0;
   endtask

   // Default ratios over the first 96 edges after reset release.
   task automatic check_defaults();
      clear();
      run(16);
      chk("def_ch0_pattern", pat[0], 16'hAAAA);
      chk("def_ch1_pattern", pat[1], 16'h8080);
      chk("def_ch2_pattern", pat[2], 16'h0800);
      chk("def_ch3_pattern", pat[3], 16'h8888);
      run(80);
      chk("def_ch0_count", cnt[0], 48);
      chk("def_ch1_count", cnt[1], 12);
      chk("def_ch2_count", cnt[2], 8);
      chk("def_ch3_count", cnt[3], 24);
   endtask

   initial begin
`ifdef SIM_TURBO_EN
      exp_turbo = 8'hAA;
`else
      exp_turbo = 8'h88;
`endif
      #12;
      chk("reset_cen", cen, 4'h0);
      chk("reset_paused", paused, 1'b0);
      tick();
      reset = 1'b0;
      check_defaults();

      // ch1 -> 3/8: pulses at offsets 3,6,8 of every 8-cycle window
      cfg(4'd1, 8'd3, 8'd8);
      chk("cfg_write_cycle_cen1", cen[1], 1'b0);
      clear();
      run(16);
      chk("cfg_ch1_pattern", pat[1], 16'hA4A4);
      chk("cfg_ch0_untouched", cnt[0], 8);
      chk("cfg_ch3_untouched", cnt[3], 4);

      // pause for 20 cycles: ch0/ch1 frozen, ch2/ch3 keep running
      pause = 1'b1;
      clear();
      run(20);
      chk("pause_paused", paused, 1'b1);
      chk("pause_ch0_count", cnt[0], 0);
      chk("pause_ch1_count", cnt[1], 0);
      chk("pause_ch2_count", cnt[2], 2);
      chk("pause_ch3_count", cnt[3], 5);
      pause = 1'b0;
      clear();
      run(8);
      chk("resume_paused", paused, 1'b0);
      chk("resume_ch1_phase", pat[1][7:0], 8'hA4);
      chk("resume_ch0_phase", pat[0][7:0], 8'h55);

      // den=0 disables; step>=den saturates to a pulse every cycle
      cfg(4'd2, 8'd1, 8'd0);
      clear();
      run(24);
      chk("den0_ch2_count", cnt[2], 0);
      cfg(4'd2, 8'd5, 8'd4);
      chk("sat_write_cycle_cen2", cen[2], 1'b0);
      clear();
      run(16);
      chk("sat_ch2_count", cnt[2], 16);

      // out-of-range channel index must change nothing
      cfg(4'd4, 8'd0, 8'd0);
      clear();
      run(8);
      chk("badch_ch0_count", cnt[0], 4);
      chk("badch_ch2_count", cnt[2], 8);

      // turbo on ch0 reprogrammed to 1/4
      cfg(4'd0, 8'd1, 8'd4);
      clear();
      run(8);
      chk("turbo_off_ch0", pat[0][7:0], 8'h88);
      turbo = 1'b1;
      clear();
      run(8);
      chk("turbo_on_ch0", pat[0][7:0], exp_turbo);
      turbo = 1'b0;
      clear();
      run(8);
      chk("turbo_back_ch0", pat[0][7:0], 8'h88);

      // asynchronous reset in the middle of a burst
      pause = 1'b1;
      tick();
      chk("burst_cen2", cen[2], 1'b1);
      chk("burst_paused", paused, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_cen", cen, 4'h0);
      chk("async_reset_paused", paused, 1'b0);
      tick();
      reset = 1'b0;
      pause = 1'b0;
      check_defaults();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
